// File: rtl/ram_arbiter.sv
// Two-requester (CPU / host loader) arbiter in front of one fixed-latency RAM.
// Optional host bus lock is compiled in when RAM_ARB_LOCK_EN is defined.
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  CpuReq,
  input  logic                  CpuWE,
  input  logic [ADDR_WIDTH-1:0] CpuAddr,
  input  logic [DATA_WIDTH-1:0] CpuWData,
  output logic [DATA_WIDTH-1:0] CpuRData,
  output logic                  CpuReady,
  input  logic                  HostReq,
  input  logic                  HostWE,
  input  logic [ADDR_WIDTH-1:0] HostAddr,
  input  logic [DATA_WIDTH-1:0] HostWData,
  output logic [DATA_WIDTH-1:0] HostRData,
  output logic                  HostReady,
  input  logic                  Halted,
`ifdef RAM_ARB_LOCK_EN
  input  logic                  HostLock,
`endif
  output logic                  RamCS,
  output logic                  RamWE,
  output logic [ADDR_WIDTH-1:0] RamAddress,
  output logic [DATA_WIDTH-1:0] RamIn,
  input  logic [DATA_WIDTH-1:0] RamOut,
  output logic [1:0]            Grant
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} stateT;

  stateT             state;
  logic [CNT_W-1:0]  waitCnt;
  logic              lastHost;
  logic              ownerHost;
  logic              ownerWE;

  logic              cpuEff;
  logic              anyReq;
  logic              pickHost;
  logic              enterDone;

  // Winner selection: host on Halted ties, otherwise alternate against lastHost.
  always_comb begin
    cpuEff = CpuReq;
`ifdef RAM_ARB_LOCK_EN
    if (HostLock && lastHost) cpuEff = 1'b0;
`endif
    anyReq    = cpuEff | HostReq;
    pickHost  = HostReq & (~cpuEff | Halted | ~lastHost);
    enterDone = (state == WAIT) && (waitCnt == '0);
  end

  // WAIT spans the RAM read pipeline so RamOut is valid on the edge entering DONE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      waitCnt    <= '0;
      lastHost   <= 1'b1;
      ownerHost  <= 1'b0;
      ownerWE    <= 1'b0;
      Grant      <= 2'b00;
      RamCS      <= 1'b0;
      RamWE      <= 1'b0;
      RamAddress <= '0;
      RamIn      <= '0;
      CpuReady   <= 1'b0;
      HostReady  <= 1'b0;
      CpuRData   <= '0;
      HostRData  <= '0;
    end else begin
      RamCS     <= 1'b0;
      RamWE     <= 1'b0;
      CpuReady  <= 1'b0;
      HostReady <= 1'b0;

      case (state)
        IDLE: begin
          if (anyReq) begin
            state      <= ACCESS;
            ownerHost  <= pickHost;
            lastHost   <= pickHost;
            Grant      <= pickHost ? 2'b10 : 2'b01;
            ownerWE    <= pickHost ? HostWE : CpuWE;
            RamWE      <= pickHost ? HostWE : CpuWE;
            RamCS      <= 1'b1;
            RamAddress <= pickHost ? HostAddr : CpuAddr;
            RamIn      <= pickHost ? HostWData : CpuWData;
          end
        end
        ACCESS: begin
          state   <= WAIT;
          waitCnt <= CNT_W'(RAM_LATENCY - 1);
        end
        WAIT: begin
          if (waitCnt != '0) waitCnt <= waitCnt - CNT_W'(1);
        end
        DONE: begin
          state <= IDLE;
          Grant <= 2'b00;
        end
        default: state <= IDLE;
      endcase

      if (enterDone) begin
        state     <= DONE;
        CpuReady  <= ~ownerHost;
        HostReady <= ownerHost;
        if (!ownerWE) begin
          if (ownerHost) HostRData <= RamOut;
          else           CpuRData  <= RamOut;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: cycle reference model on a RAM_LATENCY=1 instance plus
// directed checks, and a RAM_LATENCY=4 instance for read-latency checks.
module tb_ram_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 12;
  localparam int unsigned L1 = 1;
`ifdef RAM_ARB_LOCK_EN
  localparam bit LockOn = 1'b1;
`else
  localparam bit LockOn = 1'b0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Rst_n;
  logic          CpuReq, CpuWE, HostReq, HostWE, Halted, HostLock;
  logic [AW-1:0] CpuAddr, HostAddr;
  logic [DW-1:0] CpuWData, HostWData;

  logic [DW-1:0] CpuRData, HostRData, RamIn, RamOut;
  logic          CpuReady, HostReady, RamCS, RamWE;
  logic [AW-1:0] RamAddress;
  logic [1:0]    Grant;

  logic          cpuReq4, hostReq4;
  logic [DW-1:0] cpuRData4, hostRData4, ramIn4, ramOut4;
  logic          cpuReady4, hostReady4, ramCS4, ramWE4;
  logic [AW-1:0] ramAddress4;
  logic [1:0]    grant4;

  int nCmp = 0;
  int nBad = 0;
  bit checkEn = 1'b0;
  logic [1:0] seen [4];

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(L1)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .CpuReq(CpuReq), .CpuWE(CpuWE), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuRData(CpuRData), .CpuReady(CpuReady),
    .HostReq(HostReq), .HostWE(HostWE), .HostAddr(HostAddr), .HostWData(HostWData),
    .HostRData(HostRData), .HostReady(HostReady),
    .Halted(Halted),
`ifdef RAM_ARB_LOCK_EN
    .HostLock(HostLock),
`endif
    .RamCS(RamCS), .RamWE(RamWE), .RamAddress(RamAddress), .RamIn(RamIn),
    .RamOut(RamOut), .Grant(Grant)
  );

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(4)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n),
    .CpuReq(cpuReq4), .CpuWE(CpuWE), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuRData(cpuRData4), .CpuReady(cpuReady4),
    .HostReq(hostReq4), .HostWE(HostWE), .HostAddr(HostAddr), .HostWData(HostWData),
    .HostRData(hostRData4), .HostReady(hostReady4),
    .Halted(Halted),
`ifdef RAM_ARB_LOCK_EN
    .HostLock(HostLock),
`endif
    .RamCS(ramCS4), .RamWE(ramWE4), .RamAddress(ramAddress4), .RamIn(ramIn4),
    .RamOut(ramOut4), .Grant(grant4)
  );

  // RAM devices: data valid only in the cycle the latency allows, noise otherwise.
  logic [DW-1:0] ramMem1 [logic [AW-1:0]];
  logic [DW-1:0] ramMem4 [logic [AW-1:0]];
  logic [DW-1:0] pipe4 [4];
  assign ramOut4 = pipe4[3];

  always @(posedge Clk) begin
    if (RamCS && RamWE) ramMem1[RamAddress] = RamIn;
    if (RamCS && !RamWE) RamOut <= ramMem1.exists(RamAddress) ? ramMem1[RamAddress] : '0;
    else                 RamOut <= DW'($urandom);
  end

  always @(posedge Clk) begin
    if (ramCS4 && ramWE4) ramMem4[ramAddress4] = ramIn4;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
    if (ramCS4 && !ramWE4) pipe4[0] <= ramMem4.exists(ramAddress4) ? ramMem4[ramAddress4] : '0;
    else                   pipe4[0] <= DW'($urandom);
  end

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since the grant edge (0 = free).
  // Grant edge -> t=1 (RAM strobe); Ready in the cycle after grant edge + 1 + latency.
  int            mT;
  bit            mHost, mWe, mLast;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWData, eCpuR, eHostR;
  logic [DW-1:0] refMem [logic [AW-1:0]];
  localparam int ReadyT = L1 + 2;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mT = 0; mLast = 1'b1; eCpuR = '0; eHostR = '0;
    end else if (mT == 0) begin
      bit c, h;
      c = CpuReq && !(LockOn && HostLock && mLast);
      h = HostReq;
      if (c || h) begin
        mHost  = (c && h) ? (Halted ? 1'b1 : !mLast) : h;
        mLast  = mHost;
        mWe    = mHost ? HostWE : CpuWE;
        mAddr  = mHost ? HostAddr : CpuAddr;
        mWData = mHost ? HostWData : CpuWData;
        if (mWe) refMem[mAddr] = mWData;
        mT = 1;
      end
    end else begin
      mT++;
      if (mT == ReadyT && !mWe) begin
        if (mHost) eHostR = refMem.exists(mAddr) ? refMem[mAddr] : '0;
        else       eCpuR  = refMem.exists(mAddr) ? refMem[mAddr] : '0;
      end
      if (mT == ReadyT + 1) mT = 0;
    end
  end

  always begin
    @(posedge Clk); #2;
    if (checkEn) begin
      expectEq("grant", 32'(Grant), (mT == 0) ? 32'd0 : (mHost ? 32'd2 : 32'd1));
      expectEq("ramcs", 32'(RamCS), 32'(mT == 1));
      expectEq("ramwe", 32'(RamWE), 32'(mT == 1 && mWe));
      if (mT == 1) expectEq("ramaddr", 32'(RamAddress), 32'(mAddr));
      if (mT == 1 && mWe) expectEq("ramin", 32'(RamIn), 32'(mWData));
      expectEq("cpuready", 32'(CpuReady), 32'(mT == ReadyT && !mHost));
      expectEq("hostready", 32'(HostReady), 32'(mT == ReadyT && mHost));
      expectEq("cpurdata", 32'(CpuRData), 32'(eCpuR));
      expectEq("hostrdata", 32'(HostRData), 32'(eHostR));
    end
  end

  // sel: 0 = cpu, 1 = host, 2 = cpu on the latency-4 instance
  task automatic waitReady(input int sel, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge Clk); #2;
      n++;
      if ((sel == 0 && CpuReady) || (sel == 1 && HostReady) || (sel == 2 && cpuReady4)) break;
    end
  endtask

  task automatic recordGrants(input int n, input int dropHostAfter, input bit dropLock);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      do begin @(posedge Clk); #2; t++; end while (Grant == 2'b00 && t < 20);
      seen[k] = Grant;
      t = 0;
      do begin @(posedge Clk); #2; t++; end while (!(CpuReady || HostReady) && t < 20);
      if (k + 1 == dropHostAfter) begin
        @(negedge Clk);
        HostReq = 1'b0;
        if (dropLock) HostLock = 1'b0;
      end
    end
    @(negedge Clk);
    CpuReq = 1'b0; HostReq = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic randomPhase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (CpuReady) CpuReq = 1'b0;
      else if (!CpuReq) CpuReq = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 31) == 0) CpuReq = 1'b0;
      if (HostReady) HostReq = 1'b0;
      else if (!HostReq) HostReq = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 31) == 0) HostReq = 1'b0;
      CpuWE     = 1'($urandom_range(0, 1));
      HostWE    = 1'($urandom_range(0, 1));
      CpuAddr   = AW'($urandom_range(0, 15));
      HostAddr  = AW'($urandom_range(0, 15));
      CpuWData  = DW'($urandom);
      HostWData = DW'($urandom);
      if ($urandom_range(0, 15) == 0) Halted = ~Halted;
      if ($urandom_range(0, 15) == 0) HostLock = ~HostLock;
    end
    @(negedge Clk);
    CpuReq = 1'b0; HostReq = 1'b0; Halted = 1'b0; HostLock = 1'b0;
    repeat (12) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] a4 [4];
    logic [DW-1:0] d4 [4];
    Rst_n = 1'b1;
    CpuReq = 0; CpuWE = 0; CpuAddr = '0; CpuWData = '0;
    HostReq = 0; HostWE = 0; HostAddr = '0; HostWData = '0;
    Halted = 0; HostLock = 0; cpuReq4 = 0; hostReq4 = 0;
    #1 Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    expectEq("rst_grant", 32'(Grant), 32'd0);
    expectEq("rst_ramcs", 32'(RamCS), 32'd0);
    expectEq("rst_ramwe", 32'(RamWE), 32'd0);
    expectEq("rst_ready", 32'({CpuReady, HostReady}), 32'd0);
    expectEq("rst_rdata", 32'({CpuRData, HostRData}), 32'd0);
    Rst_n = 1'b1;
    checkEn = 1'b1;

    // Round-robin ties, CPU wins the first after reset
    @(negedge Clk);
    CpuReq = 1; HostReq = 1; CpuAddr = 24'h10; HostAddr = 24'h20;
    recordGrants(4, 0, 1'b0);
    expectEq("rr_g0", 32'(seen[0]), 32'd1);
    expectEq("rr_g1", 32'(seen[1]), 32'd2);
    expectEq("rr_g2", 32'(seen[2]), 32'd1);
    expectEq("rr_g3", 32'(seen[3]), 32'd2);

    // Halted: host wins every tie until it drops
    Halted = 1; CpuReq = 1; HostReq = 1;
    recordGrants(4, 3, 1'b0);
    expectEq("halt_g0", 32'(seen[0]), 32'd2);
    expectEq("halt_g1", 32'(seen[1]), 32'd2);
    expectEq("halt_g2", 32'(seen[2]), 32'd2);
    expectEq("halt_g3", 32'(seen[3]), 32'd1);
    Halted = 0;

    // Write 0x123 to 0x42 then read it back
    @(negedge Clk);
    CpuWE = 1; CpuAddr = 24'h42; CpuWData = 12'h123; CpuReq = 1;
    waitReady(0, n);
    expectEq("wr_latency", 32'(n), 32'd3);
    @(negedge Clk); CpuReq = 0; CpuWData = 12'hABC;
    @(negedge Clk); CpuWE = 0; CpuReq = 1;
    waitReady(0, n);
    expectEq("rd_latency", 32'(n), 32'd3);
    expectEq("rd_data", 32'(CpuRData), 32'h123);
    @(negedge Clk); CpuReq = 0;
    repeat (2) @(negedge Clk);

    // Reset during ACCESS abandons the access; the held request then completes
    CpuWE = 0; CpuAddr = 24'h42; CpuReq = 1;
    @(posedge Clk); #2;
    expectEq("rst_mid_cs_before", 32'(RamCS), 32'd1);
    #1 Rst_n = 1'b0;
    #1;
    expectEq("rst_mid_cs", 32'(RamCS), 32'd0);
    expectEq("rst_mid_grant", 32'(Grant), 32'd0);
    #1 Rst_n = 1'b1;
    waitReady(0, n);
    expectEq("rst_after_latency", 32'(n), 32'd3);
    expectEq("rst_after_data", 32'(CpuRData), 32'h123);
    @(negedge Clk); CpuReq = 0;
    repeat (2) @(negedge Clk);

`ifdef RAM_ARB_LOCK_EN
    // Locked host writes keep the CPU out until the lock falls
    HostLock = 1; HostWE = 1; HostAddr = 24'h7; HostWData = 12'h5A5;
    CpuWE = 0; CpuAddr = 24'h7; HostReq = 1; CpuReq = 1;
    recordGrants(4, 3, 1'b1);
    expectEq("lock_g0", 32'(seen[0]), 32'd2);
    expectEq("lock_g1", 32'(seen[1]), 32'd2);
    expectEq("lock_g2", 32'(seen[2]), 32'd2);
    expectEq("lock_g3", 32'(seen[3]), 32'd1);
    expectEq("lock_cpu_rd", 32'(CpuRData), 32'h5A5);
`endif

    randomPhase(3000);

    // Latency-4 instance: writes then reads, Ready six cycles after request
    for (int i = 0; i < 4; i++) begin
      a4[i] = AW'(24'h100 + 24'(i * 3));
      d4[i] = DW'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      CpuWE = (i < 4); CpuAddr = a4[i % 4]; CpuWData = d4[i % 4]; cpuReq4 = 1;
      waitReady(2, n);
      expectEq("l4_latency", 32'(n), 32'd6);
      if (i >= 4) expectEq("l4_rdata", 32'(cpuRData4), 32'(d4[i % 4]));
      @(negedge Clk); cpuReq4 = 0;
      @(negedge Clk);
    end

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
